qtpa_loop_ctrl: RTL

//  Parametrised hardware-loop controller for the issue stage; successor to the single-level LOOP/LCSET semantics.

---
 rtl/qtpa_pkg.sv | 16 +
 rtl/qtpa_loop_stack.sv | 50 +++++
 rtl/qtpa_loop_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/qtpa_pkg.sv
// Shared issue-stage types: hardware-loop FSM states, loop context layout, SR flag indices.
package qtpa_pkg;
  localparam int LOOP_DEPTH_DEFAULT = 4;
  localparam int LOOP_CNT_W         = 18;
  localparam int LOOP_PC_W          = 16;

  localparam int FLAG_LOOP_ACTIVE = 4;
  localparam int FLAG_OVF         = 5;

  typedef enum logic [1:0] {LP_IDLE, LP_ACTIVE, LP_ERROR} loop_state_t;

  typedef struct packed {
    logic [LOOP_CNT_W-1:0] count;
    logic [LOOP_PC_W-1:0]  start_pc;
  } loop_ctx_t;
endpackage

// File: rtl/qtpa_loop_stack.sv
// DEPTH-entry LIFO of loop contexts. Pop+push together replaces the top entry;
// write-top+push updates the current top and pushes above it in one cycle.
module qtpa_loop_stack
  import qtpa_pkg::*;
#(
  parameter int  DEPTH = LOOP_DEPTH_DEFAULT,
  parameter type ctx_t = loop_ctx_t
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         wr_top,
  input  ctx_t                         push_data,
  input  ctx_t                         wr_data,
  output ctx_t                         top,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         full,
  output logic                         empty
);
  localparam int DW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ctx_t            mem [DEPTH];
  logic [DW-1:0]   top_pos;
  logic [AW-1:0]   top_idx;

  assign top_pos = depth - DW'(1);
  assign top_idx = AW'(top_pos);
  assign full    = (depth == DW'(DEPTH));
  assign empty   = (depth == '0);
  assign top     = empty ? '0 : mem[top_idx];

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    // Contents are don't-care after reset; only depth is cleared.
    always_ff @(posedge clk) begin
      if (push && (pop ? (DW'(i) == top_pos) : (DW'(i) == depth)))
        mem[i] <= push_data;
      else if (wr_top && (DW'(i) == top_pos))
        mem[i] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        depth <= '0;
    else if (flush) depth <= '0;
    else            depth <= depth + DW'(push) - DW'(pop);
  end
endmodule

// File: rtl/qtpa_loop_ctrl.sv
// Nested hardware-loop controller: LCSET pushes a context, LOOP decrements/redirects
// or pops it, flush empties the stack; overflow/underflow park the FSM in ERROR.
module qtpa_loop_ctrl
  import qtpa_pkg::*;
#(
  parameter int DEPTH = LOOP_DEPTH_DEFAULT,
  parameter int CNT_W = LOOP_CNT_W,
  parameter int PC_W  = LOOP_PC_W,
  parameter int SRC_W = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        lcset_valid_i,
  input  logic [SRC_W-1:0]            lcset_count_i,
  input  logic [PC_W-1:0]             lcset_start_i,
  input  logic                        loop_valid_i,
  input  logic                        flush_i,
  input  logic                        clear_err_i,
  output logic                        redirect_valid_o,
  output logic [PC_W-1:0]             redirect_pc_o,
  output logic                        loop_active_o,
  output logic [$clog2(DEPTH+1)-1:0]  depth_o,
  output logic [CNT_W-1:0]            count_o,
  output logic                        ovf_err_o,
  output logic                        unf_err_o
);
  localparam int DW = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic [PC_W-1:0]  start_pc;
  } ctx_t;

  loop_state_t    state, state_nxt;
  ctx_t           push_ctx, wr_ctx, top_ctx;
  logic [DW-1:0]  depth;
  logic           full, empty;
  logic           st_push, st_pop, st_wr, st_flush;
  logic           ovf_set, unf_set, err_clr, redir_nxt, empty_after;
  logic [CNT_W-1:0] sat_cnt;

  // Counts above the field saturate; zero still runs the body once.
  always_comb begin
    if (lcset_count_i > SRC_W'(CNT_MAX)) sat_cnt = CNT_MAX;
    else if (lcset_count_i == '0)        sat_cnt = CNT_W'(1);
    else                                 sat_cnt = lcset_count_i[CNT_W-1:0];
  end

  assign push_ctx = '{count: sat_cnt, start_pc: lcset_start_i};
  assign wr_ctx   = '{count: top_ctx.count - CNT_W'(1), start_pc: top_ctx.start_pc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LP_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    st_push     = 1'b0;
    st_pop      = 1'b0;
    st_wr       = 1'b0;
    st_flush    = 1'b0;
    ovf_set     = 1'b0;
    unf_set     = 1'b0;
    err_clr     = 1'b0;
    redir_nxt   = 1'b0;
    empty_after = 1'b0;
    if (flush_i) begin
      st_flush  = 1'b1;
      state_nxt = (state == LP_ERROR) ? LP_ERROR : LP_IDLE;
    end else if (state == LP_ERROR) begin
      if (clear_err_i) begin
        st_flush  = 1'b1;
        err_clr   = 1'b1;
        state_nxt = LP_IDLE;
      end
    end else begin
      if (loop_valid_i) begin
        if (empty)                           unf_set = 1'b1;
        else if (top_ctx.count > CNT_W'(1)) begin
          st_wr     = 1'b1;
          redir_nxt = 1'b1;
        end else                             st_pop  = 1'b1;
      end
      // LOOP resolves first, so a popping LOOP frees a slot for the push.
      if (lcset_valid_i && !unf_set) begin
        if (full && !st_pop) ovf_set = 1'b1;
        else                 st_push = 1'b1;
      end
      if (ovf_set || unf_set) begin
        st_wr     = 1'b0;
        st_pop    = 1'b0;
        st_push   = 1'b0;
        redir_nxt = 1'b0;
        state_nxt = LP_ERROR;
      end else begin
        empty_after = !st_push && (empty || (st_pop && depth == DW'(1)));
        state_nxt   = empty_after ? LP_IDLE : LP_ACTIVE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_err_o        <= 1'b0;
      unf_err_o        <= 1'b0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
    end else begin
      if (err_clr) begin
        ovf_err_o <= 1'b0;
        unf_err_o <= 1'b0;
      end
      if (ovf_set) ovf_err_o <= 1'b1;
      if (unf_set) unf_err_o <= 1'b1;
      redirect_valid_o <= redir_nxt;
      if (redir_nxt) redirect_pc_o <= top_ctx.start_pc;
    end
  end

  qtpa_loop_stack #(.DEPTH(DEPTH), .ctx_t(ctx_t)) u_stack (
    .clk       (clk),
    .rst       (rst),
    .flush     (st_flush),
    .push      (st_push),
    .pop       (st_pop),
    .wr_top    (st_wr),
    .push_data (push_ctx),
    .wr_data   (wr_ctx),
    .top       (top_ctx),
    .depth     (depth),
    .full      (full),
    .empty     (empty)
  );

  assign loop_active_o = (state == LP_ACTIVE);
  assign depth_o       = depth;
  assign count_o       = top_ctx.count;
endmodule
